edge_event_serializer: RTL

- Downstream consumer of the 32-bit sticky negative-edge capture vector.
- Turns newly set capture bits into a stream of single event indices over a valid/ready handshake.
- Round-robin fair across bits. Each bit is reported once per arm period.
- The upstream capture vector never self-clears, so this block records which bits it has already reported.

---
 rtl/edge_event_serializer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/edge_event_serializer.sv
// Edge event serializer: turns newly captured, unreported capture bits into a
// round-robin stream of single event indices over a valid/ready handshake.
// The upstream capture vector is sticky, so reported bits are remembered here
// until a rearm pulse clears the record.
module edge_event_serializer #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] edge_i,
    input  logic [WIDTH-1:0] mask_i,
    input  logic             rearm_i,
    output logic             evt_valid_o,
    output logic [IDX_W-1:0] evt_idx_o,
    input  logic             evt_ready_i,
    output logic [WIDTH-1:0] served_o,
    output logic [CNT_W-1:0] evt_cnt_o
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_served;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_pending;
    logic [WIDTH-1:0] w_servedNext;
    logic [IDX_W-1:0] w_selIdx;
    logic             w_selFound;
    logic             w_load;
    logic             w_handshake;

    assign w_pending   = edge_i & mask_i & ~r_served;
    assign w_handshake = (r_state == OFFER) && evt_ready_i;

    assign evt_valid_o = (r_state == OFFER);
    assign evt_idx_o   = r_idx;
    assign served_o    = r_served;
    assign evt_cnt_o   = r_cnt;

    // Round-robin pick: the pending bit closest at or after the pointer wins;
    // scanning offsets downward lets the smallest offset overwrite the rest.
    always_comb begin
        w_selIdx   = '0;
        w_selFound = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_pending[r_ptr + IDX_W'(i)]) begin
                w_selIdx   = r_ptr + IDX_W'(i);
                w_selFound = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: load a selection from IDLE, hold the offer until accepted.
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_selFound) begin
                    w_load      = 1'b1;
                    w_stateNext = OFFER;
                end
            end
            OFFER: begin
                if (w_handshake) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Offered index is captured on selection and stays frozen during the offer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
        end else if (w_load) begin
            r_idx <= w_selIdx;
        end
    end

    // Pointer moves one past the accepted index, wrapping naturally at WIDTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_handshake) begin
            r_ptr <= r_idx + IDX_W'(1);
        end
    end

    // Rearm wipes the record first so a simultaneous handshake still marks its bit.
    always_comb begin
        w_servedNext = rearm_i ? '0 : r_served;
        if (w_handshake) begin
            w_servedNext[r_idx] = 1'b1;
        end
    end

    // Reported-bit record register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_served <= '0;
        end else begin
            r_served <= w_servedNext;
        end
    end

    // Accepted-event counter, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_handshake && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
